traffic_light_monitor: RTL and testbench

- Downstream checker for the traffic-light sequencer; consumes its red/amber/green lamp drives every clock.
- Verifies one-hot lamp state, legal order red->green->amber->red, and per-phase dwell against nominal tick counts.
- Reports a sticky fault with a code, the current phase, and a completed-cycle count for the lamp-driver/safety stage.

---
 rtl/traffic_pkg.sv | 45 ++++
 rtl/phase_dwell_counter.sv | 45 ++++
 rtl/traffic_light_monitor.sv | 210 +++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light sequencer and its monitor.
// Holds the phase encoding, the fault cause codes, the nominal tick defaults,
// and the monitor state type.
package traffic_pkg;

  // Phase encoding presented on the monitor phase output
  localparam logic [1:0] PH_IDLE  = 2'b00;
  localparam logic [1:0] PH_RED   = 2'b01;
  localparam logic [1:0] PH_GREEN = 2'b10;
  localparam logic [1:0] PH_AMBER = 2'b11;

  // Fault causes; a lower value has a higher priority
  localparam logic [2:0] FC_NONE  = 3'd0;
  localparam logic [2:0] FC_MULTI = 3'd1;
  localparam logic [2:0] FC_ORDER = 3'd2;
  localparam logic [2:0] FC_SHORT = 3'd3;
  localparam logic [2:0] FC_LONG  = 3'd4;
  localparam logic [2:0] FC_GAP   = 3'd5;

  // Nominal dwell defaults, shared with the sequencer
  localparam int unsigned DEF_RED_TICS   = 350;
  localparam int unsigned DEF_GREEN_TICS = 200;
  localparam int unsigned DEF_AMBER_TICS = 30;
  localparam int unsigned DEF_TOL        = 2;
  localparam int unsigned DEF_GAP_MAX    = 1;
  localparam int unsigned DEF_CNT_W      = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RED,
    ST_GREEN,
    ST_AMBER,
    ST_FAULT
  } state_t;

  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      ST_RED:   return PH_RED;
      ST_GREEN: return PH_GREEN;
      ST_AMBER: return PH_AMBER;
      default:  return PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/phase_dwell_counter.sv
// Saturating dwell counter with clear / load-1 / increment controls and an
// in-window compare of the current count against lo/hi bounds.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_clr              count <= 0 (highest priority)
//   i_load1            count <= 1 (start of a new phase)
//   i_inc              count <= count + 1, saturating at all-ones
//   i_lo, i_hi         dwell window bounds for the current phase
//   o_count            current count
//   o_below_lo         count < lo (exit now would be too short)
//   o_at_hi            count >= hi (one more clock would be too long)
module phase_dwell_counter #(
  parameter int unsigned CNT_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_load1,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_lo,
  input  logic [CNT_W-1:0] i_hi,
  output logic [CNT_W-1:0] o_count,
  output logic             o_below_lo,
  output logic             o_at_hi
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load1) begin
      r_count <= CNT_W'(1);
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count    = r_count;
  assign o_below_lo = (r_count < i_lo);
  assign o_at_hi    = (r_count >= i_hi);

endmodule

// File: rtl/traffic_light_monitor.sv
// Downstream checker for the traffic-light sequencer lamp drives.
// Checks one-hot lamps, the red->green->amber->red order, inter-phase gaps and
// per-phase dwell; latches the first fault cause until clear_fault or reset.
// Ports:
//   clock, reset_n        clock, asynchronous active-low reset
//   red, amber, green     lamp drives, sampled every rising edge
//   clear_fault           synchronous clear, returns to IDLE
//   phase                 00 idle/fault, 01 red, 10 green, 11 amber
//   dwell                 clocks the current lamp has been on (saturating)
//   fault, fault_code     sticky fault flag and first cause
//   cycles                completed red->green->amber->red cycles (wraps)
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned RED_TICS   = DEF_RED_TICS,
  parameter int unsigned GREEN_TICS = DEF_GREEN_TICS,
  parameter int unsigned AMBER_TICS = DEF_AMBER_TICS,
  parameter int unsigned TOL        = DEF_TOL,
  parameter int unsigned GAP_MAX    = DEF_GAP_MAX,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             red,
  input  logic             amber,
  input  logic             green,
  input  logic             clear_fault,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [15:0]      cycles
);

  localparam int unsigned GAP_W = $clog2(GAP_MAX + 2);

  localparam logic [CNT_W-1:0] RED_LO   = CNT_W'(RED_TICS - TOL);
  localparam logic [CNT_W-1:0] RED_HI   = CNT_W'(RED_TICS + TOL);
  localparam logic [CNT_W-1:0] GREEN_LO = CNT_W'(GREEN_TICS - TOL);
  localparam logic [CNT_W-1:0] GREEN_HI = CNT_W'(GREEN_TICS + TOL);
  localparam logic [CNT_W-1:0] AMBER_LO = CNT_W'(AMBER_TICS - TOL);
  localparam logic [CNT_W-1:0] AMBER_HI = CNT_W'(AMBER_TICS + TOL);

  state_t           r_state;
  logic [1:0]       r_phase;
  logic             r_fault;
  logic [2:0]       r_code;
  logic [15:0]      r_cycles;
  logic [GAP_W-1:0] r_gap;

  state_t           w_state_nxt;
  logic [2:0]       w_det_code;
  logic             w_enter;
  logic             w_inc;
  logic             w_gap_inc;
  logic             w_multi;
  logic             w_off;
  logic             w_own_on;
  logic             w_next_on;
  state_t           w_next_st;

  logic [1:0]       w_phase_nxt;
  logic             w_fault_nxt;
  logic [2:0]       w_code_nxt;
  logic [15:0]      w_cycles_nxt;
  logic [GAP_W-1:0] w_gap_nxt;

  logic [CNT_W-1:0] w_lo;
  logic [CNT_W-1:0] w_hi;
  logic [CNT_W-1:0] w_dwell;
  logic             w_below_lo;
  logic             w_at_hi;

  assign w_multi = (red & amber) | (red & green) | (amber & green);
  assign w_off   = ~(red | amber | green);

  // Per-phase dwell window for the single shared counter
  always_comb begin
    w_lo = '0;
    w_hi = '1;
    case (r_state)
      ST_RED:   begin w_lo = RED_LO;   w_hi = RED_HI;   end
      ST_GREEN: begin w_lo = GREEN_LO; w_hi = GREEN_HI; end
      ST_AMBER: begin w_lo = AMBER_LO; w_hi = AMBER_HI; end
      default:  ;
    endcase
  end

  phase_dwell_counter #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .i_clk      (clock),
    .i_rst_n    (reset_n),
    .i_clr      (clear_fault),
    .i_load1    (w_enter),
    .i_inc      (w_inc),
    .i_lo       (w_lo),
    .i_hi       (w_hi),
    .o_count    (w_dwell),
    .o_below_lo (w_below_lo),
    .o_at_hi    (w_at_hi)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_phase  <= PH_IDLE;
      r_fault  <= 1'b0;
      r_code   <= FC_NONE;
      r_cycles <= '0;
      r_gap    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_fault  <= w_fault_nxt;
      r_code   <= w_code_nxt;
      r_cycles <= w_cycles_nxt;
      r_gap    <= w_gap_nxt;
    end
  end

  // Next state and fault detection. Branches are mutually exclusive in
  // priority order, so the first matching cause is the reported one.
  always_comb begin
    w_state_nxt = r_state;
    w_det_code  = FC_NONE;
    w_enter     = 1'b0;
    w_inc       = 1'b0;
    w_gap_inc   = 1'b0;
    w_own_on    = 1'b0;
    w_next_on   = 1'b0;
    w_next_st   = ST_IDLE;

    case (r_state)
      ST_RED:   begin w_own_on = red;   w_next_on = green; w_next_st = ST_GREEN; end
      ST_GREEN: begin w_own_on = green; w_next_on = amber; w_next_st = ST_AMBER; end
      ST_AMBER: begin w_own_on = amber; w_next_on = red;   w_next_st = ST_RED;   end
      default:  ;
    endcase

    case (r_state)
      ST_IDLE: begin
        if (w_multi) begin
          w_det_code = FC_MULTI;
        end else if (red) begin
          w_state_nxt = ST_RED;
          w_enter     = 1'b1;
        end else if (!w_off) begin
          w_det_code = FC_ORDER;
        end
      end
      ST_RED, ST_GREEN, ST_AMBER: begin
        if (w_multi) begin
          w_det_code = FC_MULTI;
        end else if (w_off) begin
          if (r_gap >= GAP_W'(GAP_MAX)) w_det_code = FC_GAP;
          else                          w_gap_inc  = 1'b1;
        end else if (w_own_on) begin
          // Own lamp returning after a gap is an out-of-order lamp
          if (r_gap != '0)  w_det_code = FC_ORDER;
          else if (w_at_hi) w_det_code = FC_LONG;
          else              w_inc      = 1'b1;
        end else if (w_next_on) begin
          if (w_below_lo) begin
            w_det_code = FC_SHORT;
          end else begin
            w_state_nxt = w_next_st;
            w_enter     = 1'b1;
          end
        end else begin
          w_det_code = FC_ORDER;
        end
      end
      default: ;
    endcase

    if (w_det_code != FC_NONE) w_state_nxt = ST_FAULT;
    if (clear_fault)           w_state_nxt = ST_IDLE;
  end

  // Registered output values
  always_comb begin
    w_phase_nxt = phase_of(w_state_nxt);

    w_gap_nxt = r_gap;
    if (clear_fault || w_enter) w_gap_nxt = '0;
    else if (w_gap_inc)         w_gap_nxt = r_gap + 1'b1;

    w_fault_nxt = r_fault;
    w_code_nxt  = r_code;
    if (clear_fault) begin
      w_fault_nxt = 1'b0;
      w_code_nxt  = FC_NONE;
    end else if (w_det_code != FC_NONE) begin
      w_fault_nxt = 1'b1;
      w_code_nxt  = w_det_code;
    end

    w_cycles_nxt = r_cycles;
    if (w_enter && (r_state == ST_AMBER) && !clear_fault) w_cycles_nxt = r_cycles + 16'd1;
  end

  assign phase      = r_phase;
  assign dwell      = w_dwell;
  assign fault      = r_fault;
  assign fault_code = r_code;
  assign cycles     = r_cycles;

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

  localparam int RED_T   = 350;
  localparam int GREEN_T = 200;
  localparam int AMBER_T = 30;
  localparam int TOLR    = 2;
  localparam int GAPM    = 1;
  localparam int CW      = 10;

  logic          clock;
  logic          reset_n;
  logic          red, amber, green, clear_fault;
  logic [1:0]    phase;
  logic [CW-1:0] dwell;
  logic          fault;
  logic [2:0]    fault_code;
  logic [15:0]   cycles;

  traffic_light_monitor #(
    .RED_TICS   (RED_T),
    .GREEN_TICS (GREEN_T),
    .AMBER_TICS (AMBER_T),
    .TOL        (TOLR),
    .GAP_MAX    (GAPM),
    .CNT_W      (CW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .red         (red),
    .amber       (amber),
    .green       (green),
    .clear_fault (clear_fault),
    .phase       (phase),
    .dwell       (dwell),
    .fault       (fault),
    .fault_code  (fault_code),
    .cycles      (cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: lamp numbers 1=red 2=green 3=amber, 0=off
  int m_ph, m_dwell, m_gap, m_fault, m_code, m_cycles;
  int tics[4];
  int succ[4];

  task automatic model_reset();
    m_ph = 0; m_dwell = 0; m_gap = 0; m_fault = 0; m_code = 0; m_cycles = 0;
  endtask

  task automatic model_step(input logic r, input logic a, input logic g, input logic clr);
    int n, lamp, code;
    n = int'(r) + int'(a) + int'(g);
    lamp = r ? 1 : (g ? 2 : (a ? 3 : 0));
    code = 0;
    if (clr) begin
      m_fault = 0; m_code = 0; m_ph = 0; m_dwell = 0; m_gap = 0;
    end else if (m_fault == 0) begin
      if (n > 1) code = 1;
      else if (m_ph == 0) begin
        if (lamp == 1) begin m_ph = 1; m_dwell = 1; m_gap = 0; end
        else if (lamp != 0) code = 2;
      end else if (lamp == 0) begin
        if (m_gap + 1 > GAPM) code = 5;
        else m_gap++;
      end else if (lamp == m_ph && m_gap == 0) begin
        if (m_dwell + 1 > tics[m_ph] + TOLR) code = 4;
        else if (m_dwell < (1 << CW) - 1) m_dwell++;
      end else if (lamp == succ[m_ph]) begin
        if (m_dwell < tics[m_ph] - TOLR) code = 3;
        else begin
          if (m_ph == 3) m_cycles = (m_cycles + 1) % 65536;
          m_ph = lamp; m_dwell = 1; m_gap = 0;
        end
      end else code = 2;
      if (code != 0) begin m_fault = 1; m_code = code; m_ph = 0; end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".phase"},  32'(phase),      32'(m_ph));
    chk({tag, ".dwell"},  32'(dwell),      32'(m_dwell));
    chk({tag, ".fault"},  32'(fault),      32'(m_fault));
    chk({tag, ".code"},   32'(fault_code), 32'(m_code));
    chk({tag, ".cycles"}, 32'(cycles),     32'(m_cycles));
  endtask

  task automatic step(input logic r, input logic a, input logic g, input logic clr, input string tag);
    red = r; amber = a; green = g; clear_fault = clr;
    @(posedge clock);
    model_step(r, a, g, clr);
    #1;
    chk_model(tag);
  endtask

  task automatic lamp_n(input int lamp, input int n, input string tag);
    for (int i = 0; i < n; i++) step(lamp == 1, lamp == 3, lamp == 2, 1'b0, tag);
  endtask

  typedef struct {
    logic r, a, g, clr;
    int   n;
    int   ph, dw, f, code, cyc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic a, input logic g, input logic clr,
                              input int n, input int ph, input int dw, input int f,
                              input int code, input int cyc);
    vec_t v;
    v.r = r; v.a = a; v.g = g; v.clr = clr; v.n = n;
    v.ph = ph; v.dw = dw; v.f = f; v.code = code; v.cyc = cyc;
    return v;
  endfunction

  task automatic run_random(input int nseg);
    int lamp, len, gap;
    for (int s = 0; s < nseg; s++) begin
      if (m_fault != 0) begin
        step(1'b0, 1'b0, 1'b0, 1'b1, "rnd.clr");
        continue;
      end
      lamp = (m_ph == 0) ? 1 : succ[m_ph];
      if ($urandom_range(0, 11) == 0) lamp = int'($urandom_range(1, 3));
      len = tics[lamp] + int'($urandom_range(0, 8)) - 4;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 399) == 0)
          step(1'b1, lamp == 3 || lamp == 2, lamp == 2, 1'b0, "rnd.multi");
        else if ($urandom_range(0, 999) == 0)
          step(lamp == 1, lamp == 3, lamp == 2, 1'b1, "rnd.pclr");
        else
          step(lamp == 1, lamp == 3, lamp == 2, 1'b0, "rnd");
      end
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: gap = 0;
        6, 7, 8:          gap = 1;
        default:          gap = 2;
      endcase
      for (int i = 0; i < gap; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "rnd.gap");
    end
  endtask

  initial begin
    vec_t v;
    tics[0] = 0; tics[1] = RED_T; tics[2] = GREEN_T; tics[3] = AMBER_T;
    succ[0] = 1; succ[1] = 2; succ[2] = 3; succ[3] = 1;

    reset_n = 1'b0; red = 0; amber = 0; green = 0; clear_fault = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset.phase",  32'(phase),      32'd0);
    chk("reset.dwell",  32'(dwell),      32'd0);
    chk("reset.fault",  32'(fault),      32'd0);
    chk("reset.code",   32'(fault_code), 32'd0);
    chk("reset.cycles", 32'(cycles),     32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    //              r  a  g  clr  n    ph dw  f code cyc
    tbl.push_back(mk(1, 0, 0, 0, 350, 1, 350, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 200, 2, 200, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  30, 3,  30, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 350, 1, 350, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 200, 2, 200, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0,  30, 3,  30, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0,   1, 1,   1, 0, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 349, 1, 350, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0,   1, 1, 350, 0, 0, 2));   // one-clock gap ok
    tbl.push_back(mk(0, 0, 1, 0, 200, 2, 200, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0,   2, 0, 200, 1, 5, 2));   // two-clock gap
    tbl.push_back(mk(0, 0, 0, 1,   1, 0,   0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 350, 1, 350, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1, 0, 197, 2, 197, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0,   1, 0, 197, 1, 3, 2));   // green too short
    tbl.push_back(mk(0, 0, 0, 1,   1, 0,   0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 350, 1, 350, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1, 0, 198, 2, 198, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0,  30, 3,  30, 0, 0, 2));   // 198 is legal
    tbl.push_back(mk(1, 0, 0, 0,   1, 1,   1, 0, 0, 3));
    tbl.push_back(mk(1, 0, 0, 0, 349, 1, 350, 0, 0, 3));
    tbl.push_back(mk(0, 0, 1, 0, 202, 2, 202, 0, 0, 3));
    tbl.push_back(mk(0, 0, 1, 0,   1, 0, 202, 1, 4, 3));   // would reach 203
    tbl.push_back(mk(0, 0, 0, 1,   1, 0,   0, 0, 0, 3));
    tbl.push_back(mk(1, 0, 0, 0,  10, 1,  10, 0, 0, 3));
    tbl.push_back(mk(1, 1, 0, 0,   1, 0,  10, 1, 1, 3));   // two lamps
    tbl.push_back(mk(0, 0, 0, 1,   1, 0,   0, 0, 0, 3));
    tbl.push_back(mk(1, 0, 0, 0,   5, 1,   5, 0, 0, 3));
    tbl.push_back(mk(0, 1, 0, 0,   1, 0,   5, 1, 2, 3));   // red->amber
    tbl.push_back(mk(0, 0, 0, 1,   1, 0,   0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 1, 0,   1, 0,   0, 1, 2, 3));   // green from idle
    tbl.push_back(mk(0, 0, 0, 1,   1, 0,   0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 1, 1,   1, 0,   0, 0, 0, 3));   // clear beats fault
    tbl.push_back(mk(1, 0, 0, 0, 352, 1, 352, 0, 0, 3));   // hi edge legal
    tbl.push_back(mk(0, 0, 1, 0,   1, 2,   1, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 1,   1, 0,   0, 0, 0, 3));

    for (int k = 0; k < tbl.size(); k++) begin
      v = tbl[k];
      for (int i = 0; i < v.n; i++) step(v.r, v.a, v.g, v.clr, $sformatf("vec%0d.cyc", k));
      chk($sformatf("vec%0d.phase", k),  32'(phase),      32'(v.ph));
      chk($sformatf("vec%0d.dwell", k),  32'(dwell),      32'(v.dw));
      chk($sformatf("vec%0d.fault", k),  32'(fault),      32'(v.f));
      chk($sformatf("vec%0d.code", k),   32'(fault_code), 32'(v.code));
      chk($sformatf("vec%0d.cycles", k), 32'(cycles),     32'(v.cyc));
    end

    // Asynchronous reset in the middle of green
    lamp_n(1, 350, "rst.red");
    lamp_n(2, 100, "rst.green");
    chk("rst.pre.dwell", 32'(dwell), 32'd100);
    chk("rst.pre.phase", 32'(phase), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst.async.phase",  32'(phase),      32'd0);
    chk("rst.async.dwell",  32'(dwell),      32'd0);
    chk("rst.async.fault",  32'(fault),      32'd0);
    chk("rst.async.code",   32'(fault_code), 32'd0);
    chk("rst.async.cycles", 32'(cycles),     32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    lamp_n(1, 350, "rst.after");
    chk("rst.after.phase", 32'(phase), 32'd1);
    chk("rst.after.dwell", 32'(dwell), 32'd350);
    chk("rst.after.fault", 32'(fault), 32'd0);
    lamp_n(2, 1, "rst.after.g");
    chk("rst.after.gphase", 32'(phase), 32'd2);

    run_random(120);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
